// File: rtl/alu_operand_stage.sv
// Forms ALU A/B/op from register reads, immediate and forwarding; 2-entry skid buffer (HEAD/SKID).
// Latency 1 cycle push-to-out_valid; in_ready registered as !SKID valid, so a stalled ALU costs no throughput.
// Optional forwarding mux enabled by defining ALU_OPSTAGE_FWD_EN; flush drops both entries and any same-cycle push.
module alu_operand_stage #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       b_sel,
  input  logic [2:0]       op,
  input  logic             fwd_a,
  input  logic             fwd_b,
  input  logic [WIDTH-1:0] fwd_data,
  input  logic             flush,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } entry_t;

  // Encoding is {HEAD valid, SKID valid} so out_valid comes straight off a flop.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  entry_t           head_q, head_d, skid_q, skid_d, new_entry;
  logic             in_ready_q;
  logic [WIDTH-1:0] b_base;
  logic             push, pop;

  always_comb begin
    b_base = rt_data;
    case (b_sel)
      2'b00:   b_base = rt_data;
      2'b01:   b_base = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
      2'b10:   b_base = {{(WIDTH-IMM_W){1'b0}}, imm};
      default: b_base = {{(WIDTH-1){1'b0}}, 1'b1};
    endcase
  end

`ifdef ALU_OPSTAGE_FWD_EN
  assign new_entry.a  = fwd_a ? fwd_data : rs_data;
  assign new_entry.b  = fwd_b ? fwd_data : b_base;
`else
  logic unused_fwd;
  assign unused_fwd   = ^{fwd_a, fwd_b, fwd_data};
  assign new_entry.a  = rs_data;
  assign new_entry.b  = b_base;
`endif
  assign new_entry.op = op;

  assign push = in_valid & in_ready_q;
  assign pop  = state_q[1] & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = new_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            state_d = FULL;
            skid_d  = new_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= ~state_d[0];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[1];
  assign a         = head_q.a;
  assign b         = head_q.b;
  assign alu_op    = head_q.op;

endmodule
